// File: rtl/uart_rx_axis_framer.sv
// Frames bytes from a UART receiver into {last,data} FIFO entries and emits them as an AXI-Stream master.
// Define FRAMER_STATS_EN to enable the saturating frame_cnt/drop_cnt counters; otherwise both read 0.
module uart_rx_axis_framer #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 16,
  parameter int               MAX_LEN = 16,
  parameter logic [WIDTH-1:0] DELIM   = WIDTH'(8'h0A)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  output logic [WIDTH-1:0]       m_axis_data,
  output logic                   m_axis_valid,
  input  logic                   m_axis_ready,
  output logic                   m_axis_last,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   free;
  logic            overflow_q;
  logic            boundary, wr_en, wr_last, set_ovf, rd_en;
  logic [WIDTH:0]  head;

  // Free space is judged on the occupancy before any same-cycle read.
  assign free     = DEPTH_C - count_q;
  assign boundary = (rx_data == DELIM) || (byte_cnt_q == LAST_IDX);
  assign rd_en    = m_axis_valid && m_axis_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    if (rx_valid) begin
      case (state_q)
        IDLE, RUN: begin
          if (boundary) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
          end else begin
            state_d    = (free >= CW'(2)) ? RUN : DISCARD;
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
        DISCARD: begin
          if (boundary) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  // With one slot left, a non-boundary byte is written as a forced last so no open frame is stored.
  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    set_ovf = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE, RUN: begin
          if (free >= CW'(2)) begin
            wr_en   = 1'b1;
            wr_last = boundary;
          end else if (free == CW'(1)) begin
            wr_en   = 1'b1;
            wr_last = 1'b1;
            set_ovf = !boundary;
          end else begin
            set_ovf = 1'b1;
          end
        end
        default: set_ovf = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_last, rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow_q <= 1'b0;
    else if (set_ovf)      overflow_q <= 1'b1;
    else if (clr_overflow) overflow_q <= 1'b0;
  end

  assign head         = mem_q[rd_ptr_q];
  assign m_axis_valid = (count_q != '0);
  assign m_axis_data  = m_axis_valid ? head[WIDTH-1:0] : '0;
  assign m_axis_last  = m_axis_valid & head[WIDTH];
  assign fill_level   = count_q;
  assign overflow     = overflow_q;

`ifdef FRAMER_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;
  logic        drop;

  assign drop = rx_valid && !wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (wr_en && wr_last && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF)              drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule
